// File: rtl/ready_pipeline_pkg.sv
// Shared types and helpers for the ready_pipeline skid-buffer chain.
// Slice state enum values equal the {main_valid, skid_valid} bit pair.
package ready_pipeline_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } slice_state_e;

   // Never returns 0, so a zero-stage build still gets a legal one-bit port.
   function automatic int occ_width(input int num_stages);
      int w;
      w = $clog2(2 * num_stages + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ready_pipeline_skid_slice.sv
// One skid slice: the main register drives the output, and the skid register
// absorbs the beat that arrives during a stall, so in_ready comes from a flop.
module skid_slice
   import ready_pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  arst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                  main_valid_q, main_valid_d;
   logic                  skid_valid_q, skid_valid_d;
   logic                  in_hs, out_hs;
   slice_state_e          state;

   assign in_ready  = !skid_valid_q;
   assign out_data  = main_data_q;
   assign out_valid = main_valid_q;
   assign in_hs     = in_valid && !skid_valid_q;
   assign out_hs    = main_valid_q && out_ready;
   assign state     = slice_state_e'({main_valid_q, skid_valid_q});

   always_comb begin
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      case (state)
         EMPTY: begin
            if (in_hs) begin
               main_data_d  = in_data;
               main_valid_d = 1'b1;
            end
         end
         ONE: begin
            if (in_hs && out_hs) begin
               main_data_d = in_data;
            end else if (in_hs) begin
               skid_data_d  = in_data;
               skid_valid_d = 1'b1;
            end else if (out_hs) begin
               main_valid_d = 1'b0;
            end
         end
         TWO: begin
            // in_ready is low here, so only the drain direction can fire.
            if (out_hs) begin
               main_data_d  = skid_data_q;
               skid_valid_d = 1'b0;
            end
         end
         default: begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n) begin
      if (!arst_n) begin
         main_data_q  <= '0;
         skid_data_q  <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: rtl/ready_pipeline.sv
// Chain of NUM_STAGES skid slices that registers both the ready and the valid/data paths.
// Defining READY_PIPELINE_OCCUPANCY_EN adds the occupancy_o beat counter.
module ready_pipeline
   import ready_pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  arst_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   input  logic                  data_out_ready
`ifdef READY_PIPELINE_OCCUPANCY_EN
   ,
   output logic [occ_width(NUM_STAGES)-1:0] occupancy_o
`endif
);

   if (NUM_STAGES == 0) begin : g_wire
      assign data_out       = data_in;
      assign data_out_valid = data_in_valid;
      assign data_in_ready  = data_out_ready;
`ifdef READY_PIPELINE_OCCUPANCY_EN
      assign occupancy_o    = '0;
`endif
   end else begin : g_chain
      logic [DATA_WIDTH-1:0] stage_data  [NUM_STAGES+1];
      logic                  stage_valid [NUM_STAGES+1];
      logic                  stage_ready [NUM_STAGES+1];

      assign stage_data[0]           = data_in;
      assign stage_valid[0]          = data_in_valid;
      assign data_in_ready           = stage_ready[0];
      assign data_out                = stage_data[NUM_STAGES];
      assign data_out_valid          = stage_valid[NUM_STAGES];
      assign stage_ready[NUM_STAGES] = data_out_ready;

      for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slice
         skid_slice #(
            .DATA_WIDTH(DATA_WIDTH)
         ) u_slice (
            .clk_i    (clk_i),
            .arst_n   (arst_n),
            .in_data  (stage_data[i]),
            .in_valid (stage_valid[i]),
            .in_ready (stage_ready[i]),
            .out_data (stage_data[i+1]),
            .out_valid(stage_valid[i+1]),
            .out_ready(stage_ready[i+1])
         );
      end

`ifdef READY_PIPELINE_OCCUPANCY_EN
      localparam int OccWidth = occ_width(NUM_STAGES);
      logic [OccWidth-1:0] occ_q, occ_d;
      logic                occ_in_hs, occ_out_hs;

      assign occ_in_hs  = data_in_valid && data_in_ready;
      assign occ_out_hs = data_out_valid && data_out_ready;
      assign occupancy_o = occ_q;

      always_comb begin
         occ_d = occ_q;
         if (occ_in_hs && !occ_out_hs) begin
            occ_d = occ_q + 1'b1;
         end else if (occ_out_hs && !occ_in_hs) begin
            occ_d = occ_q - 1'b1;
         end
      end

      always_ff @(posedge clk_i or negedge arst_n) begin
         if (!arst_n) begin
            occ_q <= '0;
         end else begin
            occ_q <= occ_d;
         end
      end
`endif
   end

endmodule
